// File: rtl/nn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, its host and the datapath sub-controllers
// (valid pipeline, weight, tile and layering controllers).
interface nn_layer_sequencer_if #(
  parameter int LW  = 3,
  parameter int TIW = 2
);
  logic           start;
  logic [LW-1:0]  num_layers;
  logic           abort;
  logic           valid_ctrl_busy;
  logic           layer_ctrl_busy;
  logic           next_tile_ready;
  logic [2:0]     mode;
  logic           start_valid_pipeline;
  logic           start_weights;
  logic           start_input;
  logic           start_layering;
  logic           next_tile;
  logic [TIW-1:0] tile_idx;
  logic [LW-1:0]  layer_idx;
  logic           busy;
  logic           done;
  logic           error;

  modport master (
    input  start, num_layers, abort, valid_ctrl_busy, layer_ctrl_busy, next_tile_ready,
    output mode, start_valid_pipeline, start_weights, start_input, start_layering,
           next_tile, tile_idx, layer_idx, busy, done, error
  );

  modport slave (
    output start, num_layers, abort, valid_ctrl_busy, layer_ctrl_busy, next_tile_ready,
    input  mode, start_valid_pipeline, start_weights, start_input, start_layering,
           next_tile, tile_idx, layer_idx, busy, done, error
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Top-level NN sequencer: loads every row tile, then issues one layering pass per layer,
// guarded by a per-wait watchdog, an abort input and a sticky error flag.
module nn_layer_sequencer #(
  parameter int N          = 8,
  parameter int TILE       = 4,
  parameter int MAX_LAYERS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  nn_layer_sequencer_if.master bus
);
  localparam int NUM_TILES = N / TILE;
  localparam int LW        = $clog2(MAX_LAYERS + 1);
  localparam int TIW       = $clog2(NUM_TILES) + 1;
  localparam int TW        = $clog2(TIMEOUT + 1);

  localparam logic [TIW-1:0] LAST_TILE    = TIW'(NUM_TILES - 1);
  localparam logic [LW-1:0]  MAX_LAYERS_L = LW'(MAX_LAYERS);
  localparam logic [TW-1:0]  TIMEOUT_L    = TW'(TIMEOUT);
  localparam logic [2:0]     MODE_IDLE    = 3'd0;
  localparam logic [2:0]     MODE_LOAD    = 3'd1;
  localparam logic [2:0]     MODE_LAYER   = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_ISSUE_LOAD    = 4'd1,
    S_WAIT_LOAD_ON  = 4'd2,
    S_WAIT_LOAD_OFF = 4'd3,
    S_NEXT_TILE     = 4'd4,
    S_WAIT_TILE     = 4'd5,
    S_ISSUE_LAYER   = 4'd6,
    S_WAIT_LAY_ON   = 4'd7,
    S_WAIT_LAY_OFF  = 4'd8,
    S_DONE          = 4'd9,
    S_ERR           = 4'd10
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  wd_q, wd_d;
  logic [LW-1:0]  nl_q, nl_d;
  logic [TIW-1:0] tile_q, tile_d;
  logic [LW-1:0]  layer_q, layer_d;
  logic [2:0]     mode_q, mode_d;
  logic           load_q, load_d;
  logic           lay_q, lay_d;
  logic           nt_q, nt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic accept_s;
  logic abort_s;
  logic wd_expired_s;
  logic in_wait_s;

  assign accept_s     = (state_q == S_IDLE) && bus.start && !bus.abort &&
                        !bus.valid_ctrl_busy && !bus.layer_ctrl_busy;
  assign abort_s      = bus.abort && (state_q != S_IDLE);
  assign wd_expired_s = (wd_q == TIMEOUT_L);
  assign in_wait_s    = state_q inside {S_WAIT_LOAD_ON, S_WAIT_LOAD_OFF, S_WAIT_TILE,
                                        S_WAIT_LAY_ON, S_WAIT_LAY_OFF};

  // Next-state and tile/layer counter logic; an exit condition beats the watchdog.
  always_comb begin
    state_d = state_q;
    nl_d    = nl_q;
    tile_d  = tile_q;
    layer_d = layer_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          nl_d    = bus.num_layers;
          tile_d  = '0;
          layer_d = '0;
          if ((bus.num_layers == '0) || (bus.num_layers > MAX_LAYERS_L)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_ISSUE_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE_LOAD: state_d = S_WAIT_LOAD_ON;
      S_WAIT_LOAD_ON: begin
        if (bus.valid_ctrl_busy) begin
          state_d = S_WAIT_LOAD_OFF;
        end else if (wd_expired_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_LOAD_ON;
        end
      end
      S_WAIT_LOAD_OFF: begin
        if (!bus.valid_ctrl_busy) begin
          state_d = S_NEXT_TILE;
        end else if (wd_expired_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_LOAD_OFF;
        end
      end
      S_NEXT_TILE: state_d = S_WAIT_TILE;
      S_WAIT_TILE: begin
        if (bus.next_tile_ready) begin
          if (tile_q < LAST_TILE) begin
            tile_d  = tile_q + TIW'(1);
            state_d = S_ISSUE_LOAD;
          end else begin
            tile_d  = '0;
            state_d = S_ISSUE_LAYER;
          end
        end else if (wd_expired_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_TILE;
        end
      end
      S_ISSUE_LAYER: state_d = S_WAIT_LAY_ON;
      S_WAIT_LAY_ON: begin
        if (bus.layer_ctrl_busy) begin
          state_d = S_WAIT_LAY_OFF;
        end else if (wd_expired_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_LAY_ON;
        end
      end
      S_WAIT_LAY_OFF: begin
        if (!bus.layer_ctrl_busy) begin
          if (layer_q < (nl_q - LW'(1))) begin
            layer_d = layer_q + LW'(1);
            state_d = S_ISSUE_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else if (wd_expired_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_LAY_OFF;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_s) begin
      state_d = S_IDLE;
      tile_d  = '0;
      layer_d = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Watchdog restarts on every state change and only runs inside the wait states.
  always_comb begin
    wd_d = '0;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (in_wait_s) begin
      wd_d = wd_q + TW'(1);
    end else begin
      wd_d = '0;
    end
  end

  // Output decode from the current state; registered below so outputs trail the state by a cycle.
  always_comb begin
    mode_d  = MODE_IDLE;
    load_d  = 1'b0;
    lay_d   = 1'b0;
    nt_d    = 1'b0;
    busy_d  = (state_q != S_IDLE);
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          error_d = 1'b0;
        end else begin
          error_d = error_q;
        end
      end
      S_ISSUE_LOAD: begin
        mode_d = MODE_LOAD;
        load_d = 1'b1;
      end
      S_WAIT_LOAD_ON, S_WAIT_LOAD_OFF, S_WAIT_TILE: mode_d = MODE_LOAD;
      // Mode stays at load while the tile controller advances, avoiding a spurious 1->0->1 edge.
      S_NEXT_TILE: begin
        mode_d = MODE_LOAD;
        nt_d   = 1'b1;
      end
      S_ISSUE_LAYER: begin
        mode_d = MODE_LAYER;
        lay_d  = 1'b1;
      end
      S_WAIT_LAY_ON, S_WAIT_LAY_OFF: mode_d = MODE_LAYER;
      S_DONE:  done_d  = 1'b1;
      S_ERR:   error_d = 1'b1;
      default: mode_d  = MODE_IDLE;
    endcase
    if (abort_s) begin
      mode_d  = MODE_IDLE;
      load_d  = 1'b0;
      lay_d   = 1'b0;
      nt_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      error_d = error_q;
    end else begin
      busy_d = busy_d;
    end
  end

  // State, latched layer count, tile/layer counters and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      nl_q    <= '0;
      tile_q  <= '0;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      nl_q    <= nl_d;
      tile_q  <= tile_d;
      layer_q <= layer_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_IDLE;
      load_q  <= 1'b0;
      lay_q   <= 1'b0;
      nt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      load_q  <= load_d;
      lay_q   <= lay_d;
      nt_q    <= nt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.mode                 = mode_q;
  assign bus.start_valid_pipeline = load_q;
  assign bus.start_weights        = load_q;
  assign bus.start_input          = load_q;
  assign bus.start_layering       = lay_q;
  assign bus.next_tile            = nt_q;
  assign bus.tile_idx             = tile_q;
  assign bus.layer_idx            = layer_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.error                = error_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench: responders emulate the sub-controllers, a transaction-level model predicts
// the stream of pulses/events, and an independent monitor pops and compares each one.
module tb_nn_layer_sequencer;
  localparam int N          = 8;
  localparam int TILE       = 4;
  localparam int MAX_LAYERS = 4;
  localparam int TIMEOUT    = 15;
  localparam int NT         = N / TILE;
  localparam int LW         = $clog2(MAX_LAYERS + 1);
  localparam int TIW        = $clog2(NT) + 1;

  localparam int EV_LOAD  = 0;
  localparam int EV_NTILE = 1;
  localparam int EV_LAYER = 2;
  localparam int EV_DONE  = 3;
  localparam int EV_ERR   = 4;

  typedef struct {
    int kind;
    int tile;
    int layer;
    int mode;
  } ev_t;

  logic clk;
  logic rst;

  nn_layer_sequencer_if #(.LW(LW), .TIW(TIW)) bus ();

  nn_layer_sequencer #(.N(N), .TILE(TILE), .MAX_LAYERS(MAX_LAYERS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_load = 0, n_nt = 0, n_lay = 0, n_done = 0;
  logic prev_err = 1'b0;
  logic resp_vbusy = 1'b0, force_vbusy = 1'b0;
  logic resp_lbusy = 1'b0, force_lbusy = 1'b0;
  logic resp_ready = 1'b0;
  bit   v_en = 1'b1, fixed_timing = 1'b0;
  bit   v_act = 1'b0, l_act = 1'b0, t_act = 1'b0;
  int   lay_extra = 0;

  assign bus.valid_ctrl_busy = resp_vbusy | force_vbusy;
  assign bus.layer_ctrl_busy = resp_lbusy | force_lbusy;
  assign bus.next_tile_ready = resp_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input int kind, input int tile, input int layer, input int mode);
    ev_t e;
    e.kind = kind; e.tile = tile; e.layer = layer; e.mode = mode;
    return e;
  endfunction

  // Reference model: the whole event stream of one run, straight from the layer/tile loop nest.
  task automatic model_run(input int nl);
    if (nl < 1 || nl > MAX_LAYERS) begin
      exp_q.push_back(mk(EV_ERR, 0, 0, -1));
    end else begin
      for (int l = 0; l < nl; l++) begin
        for (int t = 0; t < NT; t++) begin
          exp_q.push_back(mk(EV_LOAD, t, l, 1));
          exp_q.push_back(mk(EV_NTILE, t, l, -1));
        end
        exp_q.push_back(mk(EV_LAYER, 0, l, 2));
      end
      exp_q.push_back(mk(EV_DONE, 0, nl - 1, -1));
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_tile_idx", int'(bus.tile_idx), e.tile);
      check("event_layer_idx", int'(bus.layer_idx), e.layer);
      if (e.mode >= 0) check("event_mode", int'(bus.mode), e.mode);
    end
  endtask

  // Monitor: every output event is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.start_valid_pipeline) begin
          n_load++;
          check("load_pulses_coincident", int'(bus.start_weights & bus.start_input), 1);
          observe(EV_LOAD);
        end
        if (bus.next_tile) begin
          n_nt++;
          observe(EV_NTILE);
        end
        if (bus.start_layering) begin
          n_lay++;
          observe(EV_LAYER);
        end
        if (bus.done) begin
          n_done++;
          observe(EV_DONE);
        end
        if (bus.error && !prev_err) observe(EV_ERR);
      end
      prev_err = bus.error;
    end
  end

  // Valid-pipeline controller model.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.start_valid_pipeline && v_en && !rst) begin
        v_act = 1'b1;
        repeat (fixed_timing ? 1 : $urandom_range(0, 5)) @(negedge clk);
        resp_vbusy = 1'b1;
        repeat (fixed_timing ? 6 : $urandom_range(1, 8)) @(negedge clk);
        resp_vbusy = 1'b0;
        v_act = 1'b0;
      end
    end
  end

  // Layering controller model.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.start_layering && !rst) begin
        l_act = 1'b1;
        repeat (fixed_timing ? 1 : $urandom_range(0, 5)) @(negedge clk);
        resp_lbusy = 1'b1;
        repeat ((fixed_timing ? 6 : $urandom_range(1, 6)) + lay_extra) @(negedge clk);
        resp_lbusy = 1'b0;
        l_act = 1'b0;
      end
    end
  end

  // Tile controller model.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.next_tile && !rst) begin
        t_act = 1'b1;
        repeat (fixed_timing ? 1 : $urandom_range(0, 6)) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        t_act = 1'b0;
      end
    end
  end

  function automatic int any_out();
    return int'((bus.mode != 3'd0) | bus.start_valid_pipeline | bus.start_weights |
                bus.start_input | bus.start_layering | bus.next_tile | (bus.tile_idx != '0) |
                (bus.layer_idx != '0) | bus.busy | bus.done | bus.error);
  endfunction

  // Issue a start at a negedge while idle; checks the accept latency.
  task automatic pulse_start(input int nl);
    bus.num_layers = LW'(nl);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept_edge", int'(bus.busy), 0);
    check("error_cleared_on_accept", int'(bus.error), 0);
    @(negedge clk);
    check("busy_after_second_edge", int'(bus.busy), 1);
    check("load_after_second_edge", int'(bus.start_valid_pipeline),
          (nl >= 1 && nl <= MAX_LAYERS) ? 1 : 0);
  endtask

  task automatic start_run(input int nl);
    model_run(nl);
    pulse_start(nl);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while ((bus.busy || exp_q.size() != 0 || v_act || l_act || t_act) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({name, "_completes"}, int'(i < 3000), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d_load, d_nt, d_lay, d_done, cyc, nl;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.num_layers = '0;
    bus.abort = 1'b0;
    #1 rst = 1'b1;
    #2 check("reset_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", any_out(), 0);

    // Directed: two layers with fixed responder timing.
    fixed_timing = 1'b1;
    d_load = n_load; d_nt = n_nt; d_lay = n_lay; d_done = n_done;
    start_run(2);
    wait_idle("directed_run");
    check("directed_load_count", n_load - d_load, 4);
    check("directed_next_tile_count", n_nt - d_nt, 4);
    check("directed_layering_count", n_lay - d_lay, 2);
    check("directed_done_count", n_done - d_done, 1);
    check("directed_error", int'(bus.error), 0);
    fixed_timing = 1'b0;

    // Randomized runs, including illegal layer counts.
    for (int r = 0; r < 10; r++) begin
      nl = $urandom_range(0, MAX_LAYERS + 1);
      start_run(nl);
      wait_idle("random_run");
    end

    // Watchdog: valid controller never answers.
    v_en = 1'b0;
    d_done = n_done;
    exp_q.push_back(mk(EV_LOAD, 0, 0, 1));
    exp_q.push_back(mk(EV_ERR, 0, 0, -1));
    pulse_start(1);
    cyc = 0;
    while (!bus.error && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("watchdog_latency", cyc, TIMEOUT + 2);
    check("watchdog_error", int'(bus.error), 1);
    @(negedge clk);
    check("busy_after_watchdog", int'(bus.busy), 0);
    v_en = 1'b1;
    wait_idle("watchdog");
    check("watchdog_no_done", n_done - d_done, 0);
    check("error_sticky", int'(bus.error), 1);

    // Illegal layer counts at both ends.
    for (int k = 0; k < 2; k++) begin
      start_run((k == 0) ? 0 : MAX_LAYERS + 1);
      @(negedge clk);
      check("cfg_err_busy_low", int'(bus.busy), 0);
      check("cfg_err_error", int'(bus.error), 1);
      wait_idle("cfg_err");
    end

    // Abort during WAIT_LAY_OFF of layer 0.
    lay_extra = 6;
    d_lay = n_lay; d_done = n_done;
    start_run(2);
    cyc = 0;
    while (!(n_lay > d_lay && bus.layer_ctrl_busy) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_layer_wait", int'(cyc < 500), 1);
    @(negedge clk);
    bus.abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_mode", int'(bus.mode), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_tile_idx", int'(bus.tile_idx), 0);
    check("abort_layer_idx", int'(bus.layer_idx), 0);
    repeat (30) @(negedge clk);
    check("abort_no_more_layering", n_lay - d_lay, 1);
    check("abort_no_done", n_done - d_done, 0);
    lay_extra = 0;
    wait_idle("abort");

    // Abort together with start in IDLE: start not accepted.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.num_layers = LW'(1);
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle_blocks_start", int'(bus.busy), 0);

    // Start ignored while a sub-controller is busy, and again mid-run.
    force_lbusy = 1'b1;
    bus.num_layers = LW'(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("start_ignored_when_busy", int'(bus.busy), 0);
    force_lbusy = 1'b0;
    @(negedge clk);
    d_done = n_done;
    start_run($urandom_range(1, MAX_LAYERS));
    repeat (6) @(negedge clk);
    check("midrun_busy", int'(bus.busy), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("ignored_start");
    check("single_done", n_done - d_done, 1);

    // Asynchronous reset mid-load, then a fresh run.
    start_run(2);
    cyc = 0;
    while (!bus.valid_ctrl_busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check("async_reset_outputs_zero", any_out(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle("reset_recovery");
    d_done = n_done;
    start_run($urandom_range(1, MAX_LAYERS));
    wait_idle("post_reset_run");
    check("post_reset_done", n_done - d_done, 1);
    check("post_reset_error", int'(bus.error), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
